// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Internal logic is active-high; pin polarity is applied only at the output register.
package seg_pkg;

    localparam int SEG_W = 8;
    localparam int PAT_W = 7;

    // Width of a digit index (at least one bit).
    function automatic int dig_w(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

    // Pin level that means "off" for the chosen polarity.
    function automatic logic inactive_bit(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timebase: per-slot refresh counter, digit index, frame pulse and blink phase.
// Everything holds while en_i is low, so scanning resumes where it stopped.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en_i,
    output logic [$clog2(REFRESH_DIV)-1:0]   cnt_o,
    output logic [dig_w(NUM_DIGITS)-1:0]     dig_sel_o,
    output logic                             frame_tick_o,
    output logic                             blink_hidden_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int SEL_W = dig_w(NUM_DIGITS);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             tick_q, tick_d;
    logic             hidden_q, hidden_d;

    always_comb begin
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        blk_d    = blk_q;
        tick_d   = 1'b0;
        hidden_d = hidden_q;
        if (en_i) begin
            if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_d = '0;
                if (sel_q == SEL_W'(NUM_DIGITS - 1)) begin
                    sel_d  = '0;
                    tick_d = 1'b1;
                    // Blink phase flips on a frame boundary so a frame is never split.
                    if (blk_q == BLK_W'(BLINK_FRAMES - 1)) begin
                        blk_d    = '0;
                        hidden_d = ~hidden_q;
                    end else begin
                        blk_d = blk_q + 1'b1;
                    end
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sel_q    <= '0;
            blk_q    <= '0;
            tick_q   <= 1'b0;
            hidden_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            blk_q    <= blk_d;
            tick_q   <= tick_d;
            hidden_q <= hidden_d;
        end
    end

    assign cnt_o          = cnt_q;
    assign dig_sel_o      = sel_q;
    assign frame_tick_o   = tick_q;
    assign blink_hidden_o = hidden_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: frame-synchronous double buffer, per-digit
// blank/blink/ghost gating and a single skew-free output register for both buses.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GHOST_CYCLES = 500,
    parameter int BLINK_FRAMES = 128,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            load,
    input  logic [PAT_W*NUM_DIGITS-1:0]     patterns,
    input  logic [NUM_DIGITS-1:0]           dots,
    input  logic [NUM_DIGITS-1:0]           blank,
    input  logic [NUM_DIGITS-1:0]           blink,
    output logic [SEG_W-1:0]                segments,
    output logic [NUM_DIGITS-1:0]           anodes,
    output logic [dig_w(NUM_DIGITS)-1:0]    dig_sel,
    output logic                            frame_tick
);

    localparam int   CNT_W = $clog2(REFRESH_DIV);
    localparam int   SEL_W = dig_w(NUM_DIGITS);
    localparam logic IDLE  = inactive_bit(ACTIVE_LOW);

    logic [CNT_W-1:0] cnt_w;
    logic [SEL_W-1:0] sel_w;
    logic             tick_w;
    logic             blink_hidden_w;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (en),
        .cnt_o          (cnt_w),
        .dig_sel_o      (sel_w),
        .frame_tick_o   (tick_w),
        .blink_hidden_o (blink_hidden_w)
    );

    logic [PAT_W*NUM_DIGITS-1:0] pend_pat_q, act_pat_q;
    logic [NUM_DIGITS-1:0]       pend_dot_q, pend_blank_q, pend_blink_q;
    logic [NUM_DIGITS-1:0]       act_dot_q, act_blank_q, act_blink_q;
    logic                        dirty_q;
    logic                        commit;

    assign commit = tick_w && dirty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_pat_q   <= '0;
            pend_dot_q   <= '0;
            pend_blank_q <= '0;
            pend_blink_q <= '0;
            dirty_q      <= 1'b0;
            act_pat_q    <= '0;
            act_dot_q    <= '0;
            // A cleared display shows nothing, so all digits start blanked.
            act_blank_q  <= '1;
            act_blink_q  <= '0;
        end else begin
            if (commit) begin
                act_pat_q   <= pend_pat_q;
                act_dot_q   <= pend_dot_q;
                act_blank_q <= pend_blank_q;
                act_blink_q <= pend_blink_q;
            end
            if (load) begin
                pend_pat_q   <= patterns;
                pend_dot_q   <= dots;
                pend_blank_q <= blank;
                pend_blink_q <= blink;
                dirty_q      <= 1'b1;
            end else if (commit) begin
                dirty_q <= 1'b0;
            end
        end
    end

    // During the commit cycle show the data being committed so frame 0 never tears.
    logic [PAT_W*NUM_DIGITS-1:0] disp_pat;
    logic [NUM_DIGITS-1:0]       disp_dot, disp_blank, disp_blink, onehot;
    logic [PAT_W-1:0]            pat_arr [NUM_DIGITS];

    assign disp_pat   = commit ? pend_pat_q   : act_pat_q;
    assign disp_dot   = commit ? pend_dot_q   : act_dot_q;
    assign disp_blank = commit ? pend_blank_q : act_blank_q;
    assign disp_blink = commit ? pend_blink_q : act_blink_q;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign pat_arr[gi] = disp_pat[PAT_W*gi +: PAT_W];
        assign onehot[gi]  = (sel_w == SEL_W'(gi));
    end

    logic in_ghost;
    if (GHOST_CYCLES == 0) begin : g_no_ghost
        assign in_ghost = 1'b0;
    end else begin : g_ghost
        assign in_ghost = (cnt_w < CNT_W'(GHOST_CYCLES));
    end

    logic                  visible;
    logic [SEG_W-1:0]      seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;

    always_comb begin
        visible = en && !disp_blank[sel_w] && !(disp_blink[sel_w] && blink_hidden_w) && !in_ghost;
        seg_raw = '0;
        an_raw  = '0;
        if (visible) begin
            seg_raw = {pat_arr[sel_w], disp_dot[sel_w]};
            an_raw  = onehot;
        end
    end

    logic [SEG_W-1:0]      segments_q;
    logic [NUM_DIGITS-1:0] anodes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments_q <= {SEG_W{IDLE}};
            anodes_q   <= {NUM_DIGITS{IDLE}};
        end else begin
            segments_q <= seg_raw ^ {SEG_W{IDLE}};
            anodes_q   <= an_raw ^ {NUM_DIGITS{IDLE}};
        end
    end

    assign segments   = segments_q;
    assign anodes     = anodes_q;
    assign dig_sel    = sel_w;
    assign frame_tick = tick_w;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed scoreboard bench: stimulus queues hand-computed pin values per cycle,
// an independent monitor compares them on the falling clock edge.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [27:0] patterns = '0;
    logic [3:0]  dots = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink = '0;
    logic [7:0]  segments;
    logic [3:0]  anodes;
    logic [1:0]  dig_sel;
    logic        frame_tick;

    seg_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .GHOST_CYCLES (2),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .patterns   (patterns),
        .dots       (dots),
        .blank      (blank),
        .blink      (blink),
        .segments   (segments),
        .anodes     (anodes),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Posedges since the last reset release.
    int cyc = 0;
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        bit          async;
        int          kind;   // 0 pins {anodes,segments}, 1 dig_sel, 2 frame_tick
        logic [11:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    localparam logic [11:0] DARK = 12'hFFF;
    localparam logic [27:0] PAT_P = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [27:0] PAT_A = {7'h01, 7'h02, 7'h04, 7'h08};
    localparam logic [27:0] PAT_B = {7'h10, 7'h20, 7'h40, 7'h3F};
    localparam logic [27:0] PAT_C = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

    function automatic logic [11:0] lit(int d, logic [6:0] p, logic dp);
        logic [3:0] an;
        logic [7:0] sg;
        an = 4'b0001 << d;
        sg = {p, dp};
        return {~an, ~sg};
    endfunction

    function automatic void push(int c, bit a, int k, logic [11:0] v, string n);
        exp_t e;
        e.cyc = c; e.async = a; e.kind = k; e.val = v; e.name = n;
        sb.push_back(e);
    endfunction

    task automatic compare(input exp_t e);
        logic [11:0] act;
        case (e.kind)
            0:       act = {anodes, segments};
            1:       act = {10'd0, dig_sel};
            default: act = {11'd0, frame_tick};
        endcase
        checks++;
        if (act !== e.val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", e.name, cyc, act, e.val);
        end else begin
            $display("ok   %s cyc=%0d val=%h", e.name, cyc, act);
        end
    endtask

    // Clocked monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && !sb[0].async && rst_n && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s missed cyc=%0d want_cyc=%0d", e.name, cyc, e.cyc);
                end else begin
                    compare(e);
                end
            end
        end
    end

    // Asynchronous reset monitor: checks without waiting for a clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge rst_n);
            #1;
            while (sb.size() > 0 && sb[0].async) begin
                e = sb.pop_front();
                compare(e);
            end
        end
    end

    task automatic at(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) begin
            errors++;
            $display("FAIL wait_timeout got=%0d want=%0d", cyc, n);
        end
    endtask

    task automatic do_load(input logic [27:0] p, input logic [3:0] d,
                           input logic [3:0] bl, input logic [3:0] bk);
        patterns = p; dots = d; blank = bl; blink = bk;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        // Reset state, idle scan, first commit, ghost edges.
        push(0, 1, 0, DARK, "rst_pins");
        push(0, 1, 1, 12'd0, "rst_sel");
        push(0, 1, 2, 12'd0, "rst_tick");
        push(1, 0, 0, DARK, "idle_pins");
        push(4, 0, 1, 12'd0, "sel0");
        push(10, 0, 0, DARK, "idle_pins");
        push(12, 0, 1, 12'd1, "sel1");
        push(20, 0, 1, 12'd2, "sel2");
        push(28, 0, 1, 12'd3, "sel3");
        push(30, 0, 0, DARK, "idle_pins");
        push(31, 0, 2, 12'd0, "tick_before");
        push(32, 0, 2, 12'd1, "tick_wrap");
        push(33, 0, 2, 12'd0, "tick_after");
        push(36, 0, 1, 12'd0, "sel_wrap0");
        push(44, 0, 0, DARK, "pre_commit");
        push(64, 0, 2, 12'd1, "tick_f2");
        push(66, 0, 0, DARK, "ghost_cnt1");
        push(67, 0, 0, lit(0, 7'h66, 1'b1), "d0_cnt2");
        push(72, 0, 0, lit(0, 7'h66, 1'b1), "d0_cnt7");
        push(73, 0, 0, DARK, "d1_ghost");
        push(76, 0, 0, lit(1, 7'h4F, 1'b0), "d1_vis");
        push(84, 0, 0, lit(2, 7'h5B, 1'b1), "d2_vis");
        push(92, 0, 0, lit(3, 7'h06, 1'b0), "d3_vis");
        // Blink on digit 1.
        push(108, 0, 0, lit(1, 7'h4F, 1'b0), "noblink_hidden_phase");
        push(140, 0, 0, lit(1, 7'h4F, 1'b0), "blink_vis_f4");
        push(172, 0, 0, lit(1, 7'h4F, 1'b0), "blink_vis_f5");
        push(196, 0, 0, lit(0, 7'h66, 1'b1), "blink_other_f6");
        push(204, 0, 0, DARK, "blink_dark_f6");
        push(236, 0, 0, DARK, "blink_dark_f7");
        push(268, 0, 0, lit(1, 7'h4F, 1'b0), "blink_vis_f8");
        // Blank on digit 3.
        push(316, 0, 0, lit(3, 7'h06, 1'b0), "pre_blank_d3");
        push(340, 0, 0, lit(2, 7'h5B, 1'b1), "blank_other_d2");
        push(348, 0, 0, DARK, "blank_d3");
        // Load coincident with frame_tick.
        push(352, 0, 2, 12'd1, "tick_f11");
        push(354, 0, 0, DARK, "ghost_f11");
        push(355, 0, 0, lit(0, 7'h08, 1'b0), "old_pend_d0");
        push(364, 0, 0, lit(1, 7'h04, 1'b0), "old_pend_d1");
        push(388, 0, 0, lit(0, 7'h3F, 1'b1), "new_data_d0");
        push(396, 0, 0, lit(1, 7'h40, 1'b1), "new_data_d1");
        // en hold then async reset.
        push(403, 0, 0, lit(2, 7'h20, 1'b1), "pre_hold");
        push(404, 0, 0, DARK, "hold_dark");
        push(408, 0, 0, DARK, "hold_dark");
        push(408, 0, 1, 12'd2, "hold_sel");
        push(413, 0, 0, DARK, "hold_dark");
        push(414, 0, 0, lit(2, 7'h20, 1'b1), "resume");
        push(417, 0, 1, 12'd2, "resume_sel");
        push(418, 0, 1, 12'd3, "resume_sel_adv");
        push(421, 0, 0, lit(3, 7'h10, 1'b1), "pre_reset");
        push(0, 1, 0, DARK, "async_rst_pins");
        push(0, 1, 1, 12'd0, "async_rst_sel");
        push(0, 1, 2, 12'd0, "async_rst_tick");

        #3 rst_n = 1'b0;
        #20;
        @(negedge clk);
        en = 1'b1;
        rst_n = 1'b1;

        at(40);  do_load(PAT_P, 4'b0101, 4'b0000, 4'b0000);
        at(100); do_load(PAT_P, 4'b0101, 4'b0000, 4'b0010);
        at(300); do_load(PAT_P, 4'b0101, 4'b1000, 4'b0000);
        at(330); do_load(PAT_A, 4'b0000, 4'b0000, 4'b0000);
        at(352); do_load(PAT_B, 4'b1111, 4'b0000, 4'b0000);
        at(403); en = 1'b0;
        at(413); en = 1'b1;
        at(419); do_load(PAT_C, 4'b1111, 4'b0000, 4'b0000);
        at(421);
        #2 rst_n = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Scan restarts at digit 0 / count 0 and the abandoned load never commits.
        push(3, 0, 0, DARK, "post_rst_pins");
        push(7, 0, 1, 12'd0, "post_rst_sel0");
        push(8, 0, 1, 12'd1, "post_rst_sel1");
        push(31, 0, 2, 12'd0, "post_rst_tick_before");
        push(32, 0, 2, 12'd1, "post_rst_tick");
        push(36, 0, 0, DARK, "no_stale_commit");
        push(44, 0, 0, DARK, "no_stale_commit");

        at(46);
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s unchecked want_cyc=%0d", e.name, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
